multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL provide parameter ALUCTL_W, default 4, width of ALUControl (legal ≥4; upper bits above 4 driven 0).
REQ-002 SHALL provide parameter MUL_EN, default 1, enabling the multiply instruction path.
REQ-003 SHALL provide parameter MUL_LAT, default 4, cycles spent in MULWAIT (legal 1..15).
REQ-004 SHALL use one clock and a synchronous, active-high reset.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 reset  in  1  synchronous active-high reset.
REQ-007 Op  in  2  instruction bits 27:26.
REQ-008 Funct  in  6  instruction bits 25:20 (I, cmd[3:0], S).
REQ-009 Rd  in  4  destination register.
REQ-010 IsMul  in  1  instruction bits 7:4 == 1001 with Op=00, Funct[5]=0.
REQ-011 IRWrite, NextPC, RegW, MemW, PCS  out  1 each  write enables; unconditional, gated by external condition logic.
REQ-012 AdrSrc, ALUSrcA  out  1 each  address mux select and ALU A select (1=PC).
REQ-013 ALUSrcB, ResultSrc, ImmSrc, RegSrc  out  2 each  datapath mux selects.
REQ-014 ALUControl  out  ALUCTL_W; FlagW  out  2.
REQ-015 Illegal  out  1  one-cycle pulse on an unsupported encoding.

Function
REQ-016 SHALL implement a Moore FSM: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, MULWAIT, ALUWB, BRANCH.
REQ-017 FETCH: IRWrite=1, NextPC=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10; next DECODE.
REQ-018 DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10; next: Op=01→MEMADR; Op=10→BRANCH; Op=00 with IsMul&MUL_EN→MULWAIT; Op=00 with Funct[5]→EXECI, else EXECR; Op=11, or IsMul with MUL_EN=0, or an unsupported cmd→FETCH with Illegal=1 for that cycle.
REQ-019 MEMADR: ALUSrcA=0, ALUSrcB=01; next MEMRD if Funct[0], else MEMWR.
REQ-020 MEMRD: AdrSrc=1 → MEMWB; MEMWB: ResultSrc=01, RegW=1 → FETCH; MEMWR: AdrSrc=1, MemW=1 → FETCH.
REQ-021 EXECR: ALUSrcA=0, ALUSrcB=00; EXECI: ALUSrcA=0, ALUSrcB=01; both go to ALUWB, except CMP (cmd 1010), which goes to FETCH.
REQ-022 MULWAIT: 4-bit counter loaded with MUL_LAT-1 on entry from DECODE and decremented each cycle; exits to ALUWB in the cycle the counter reads 0; total residency is exactly MUL_LAT cycles.
REQ-023 ALUWB: ResultSrc=00, RegW=1, PCS=1 iff Rd==1111; next FETCH.
REQ-024 BRANCH: ALUSrcA=0, ALUSrcB=01, ResultSrc=10, PCS=1; next FETCH.
REQ-025 Outputs not listed for a state SHALL be 0; AdrSrc, ALUSrcA, ALUSrcB and ResultSrc SHALL be held at the listed values for the whole state.
REQ-026 ImmSrc/RegSrc SHALL be combinational from Op: 00→ImmSrc 00, RegSrc 00; 01→ImmSrc 01, RegSrc Funct[0]?00:10; 10→ImmSrc 10, RegSrc 01; 11→00.
REQ-027 ALUControl SHALL be combinational: in EXECR, EXECI, MULWAIT and ALUWB it decodes cmd: ADD 0100→0000, SUB 0010→0001, AND 0000→0010, ORR 1100→0011, EOR 0001→0100, MOV 1101→1010, CMP 1010 (S=1)→0001, multiply→0101; in all other states it is 0000 (ADD).
REQ-028 CMP with S=0 and any unlisted cmd SHALL be unsupported (REQ-018).
REQ-029 FlagW SHALL be nonzero only in EXECR/EXECI/MULWAIT: FlagW[1]=S; FlagW[0]=S & (ALUControl ∈ {0000,0001}); CMP forces FlagW=11.
REQ-030 Op, Funct, Rd and IsMul SHALL be sampled from the instruction register and treated as stable from DECODE through the end of the instruction.

Reset
REQ-031 While reset=1, every output SHALL be 0 (including IRWrite and NextPC); the FSM SHALL enter FETCH and the MUL counter SHALL clear.
REQ-032 Reset asserted in any state, including mid-MULWAIT, SHALL abort the instruction, and the cycle after reset deasserts SHALL be FETCH.

Verification
REQ-033 ADD R1,R2,R3 (Op=00, Funct=001000, Rd=0001) → FETCH, DECODE, EXECR, ALUWB; ALUControl=0000, RegW=1 only in ALUWB, PCS=0; 4 cycles.
REQ-034 LDR (Op=01, Funct=011001) → 5 cycles; MemW never 1; RegW=1 and ResultSrc=01 in MEMWB; STR (Funct=011000) → 4 cycles with MemW=1 only in MEMWR.
REQ-035 MUL with MUL_LAT=4 → exactly 4 MULWAIT cycles, then ALUWB; ALUControl=0101; with MUL_EN=0, Illegal=1 and FETCH follows DECODE.
REQ-036 CMP (Funct=010101) → FlagW=11, no ALUWB, RegW never 1; ADD to R15 (Rd=1111) → PCS=1 in ALUWB; B (Op=10) → PCS=1 in BRANCH.
REQ-037 Op=11 → Illegal pulse for exactly one cycle, then normal fetch of the next instruction.
REQ-038 reset pulsed during the 2nd MULWAIT cycle → all enables 0 while reset is high; FETCH with IRWrite=1 the cycle after release.

Source files
------------

// File: rtl/multicycle_control.sv
// Multicycle ARM-subset control unit: Moore FSM sequencing fetch/decode/execute,
// plus the datapath decode for the immediate/register selects, ALU control and flag writes.
module multicycle_control #(
  parameter int unsigned ALUCTL_W = 4,
  parameter int unsigned MUL_EN   = 1,
  parameter int unsigned MUL_LAT  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          Op,
  input  logic [5:0]          Funct,
  input  logic [3:0]          Rd,
  input  logic                IsMul,
  output logic                IRWrite,
  output logic                NextPC,
  output logic                RegW,
  output logic                MemW,
  output logic                PCS,
  output logic                AdrSrc,
  output logic                ALUSrcA,
  output logic [1:0]          ALUSrcB,
  output logic [1:0]          ResultSrc,
  output logic [1:0]          ImmSrc,
  output logic [1:0]          RegSrc,
  output logic [ALUCTL_W-1:0] ALUControl,
  output logic [1:0]          FlagW,
  output logic                Illegal
);

  localparam int unsigned CNT_W    = 4;
  localparam logic        MUL_ON   = (MUL_EN != 0);
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_EXECR, S_EXECI, S_MULWAIT, S_ALUWB, S_BRANCH
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [3:0] cmd;
  logic       s_bit;
  logic       dp_ok;
  logic       is_cmp;
  logic       mul_sel;
  logic       decode_bad;

  // Instruction classification shared by sequencing and output decode
  always_comb begin
    cmd     = Funct[4:1];
    s_bit   = Funct[0];
    is_cmp  = (cmd == 4'b1010);
    mul_sel = IsMul && MUL_ON;
    dp_ok   = 1'b0;
    case (cmd)
      4'b0100, 4'b0010, 4'b0000,
      4'b1100, 4'b0001, 4'b1101: dp_ok = 1'b1;
      4'b1010:                   dp_ok = s_bit;
      default:                   dp_ok = 1'b0;
    endcase
    decode_bad = (Op == 2'b11) ||
                 ((Op == 2'b00) && (IsMul ? !MUL_ON : !dp_ok));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        if (decode_bad)        state_d = S_FETCH;
        else if (Op == 2'b01)  state_d = S_MEMADR;
        else if (Op == 2'b10)  state_d = S_BRANCH;
        else if (mul_sel) begin
          state_d = S_MULWAIT;
          cnt_d   = MUL_LOAD;
        end
        else if (Funct[5])     state_d = S_EXECI;
        else                   state_d = S_EXECR;
      end
      S_MEMADR: state_d = Funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = S_MEMWB;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  state_d = S_FETCH;
      S_EXECR,
      S_EXECI:  state_d = is_cmp ? S_FETCH : S_ALUWB;
      // Counter reads 0 in the last of MUL_LAT residency cycles
      S_MULWAIT: begin
        if (cnt_q == '0) state_d = S_ALUWB;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      S_ALUWB:  state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  logic [3:0] alu4;

  // Outputs forced to 0 while reset is high, independent of the stale state
  always_comb begin
    IRWrite    = 1'b0;
    NextPC     = 1'b0;
    RegW       = 1'b0;
    MemW       = 1'b0;
    PCS        = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    ImmSrc     = 2'b00;
    RegSrc     = 2'b00;
    FlagW      = 2'b00;
    Illegal    = 1'b0;
    alu4       = 4'b0000;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          IRWrite = 1'b1; NextPC = 1'b1; ALUSrcA = 1'b1;
          ALUSrcB = 2'b10; ResultSrc = 2'b10;
        end
        S_DECODE: begin
          ALUSrcA = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10;
          Illegal = decode_bad;
        end
        S_MEMADR: ALUSrcB = 2'b01;
        S_MEMRD:  AdrSrc  = 1'b1;
        S_MEMWB:  begin ResultSrc = 2'b01; RegW = 1'b1; end
        S_MEMWR:  begin AdrSrc = 1'b1; MemW = 1'b1; end
        S_EXECI:  ALUSrcB = 2'b01;
        S_ALUWB:  begin RegW = 1'b1; PCS = (Rd == 4'b1111); end
        S_BRANCH: begin ALUSrcB = 2'b01; ResultSrc = 2'b10; PCS = 1'b1; end
        default: ;
      endcase

      case (Op)
        2'b01:   begin ImmSrc = 2'b01; RegSrc = Funct[0] ? 2'b00 : 2'b10; end
        2'b10:   begin ImmSrc = 2'b10; RegSrc = 2'b01; end
        default: ;
      endcase

      if (state_q == S_EXECR || state_q == S_EXECI ||
          state_q == S_MULWAIT || state_q == S_ALUWB) begin
        if (mul_sel) alu4 = 4'b0101;
        else begin
          case (cmd)
            4'b0100: alu4 = 4'b0000;
            4'b0010: alu4 = 4'b0001;
            4'b0000: alu4 = 4'b0010;
            4'b1100: alu4 = 4'b0011;
            4'b0001: alu4 = 4'b0100;
            4'b1101: alu4 = 4'b1010;
            4'b1010: alu4 = 4'b0001;
            default: alu4 = 4'b0000;
          endcase
        end
      end

      if (state_q == S_EXECR || state_q == S_EXECI || state_q == S_MULWAIT) begin
        if (is_cmp && !mul_sel) FlagW = 2'b11;
        else FlagW = {s_bit, s_bit & ((alu4 == 4'b0000) || (alu4 == 4'b0001))};
      end
    end
  end

  assign ALUControl = ALUCTL_W'(alu4);

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class cycle by cycle
// and compares every control output against hand-derived values.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic       IsMul;

  logic       IRWrite, NextPC, RegW, MemW, PCS, AdrSrc, ALUSrcA, Illegal;
  logic [1:0] ALUSrcB, ResultSrc, ImmSrc, RegSrc, FlagW;
  logic [3:0] ALUControl;

  logic       n_IRWrite, n_NextPC, n_RegW, n_MemW, n_PCS, n_AdrSrc, n_ALUSrcA, n_Illegal;
  logic [1:0] n_ALUSrcB, n_ResultSrc, n_ImmSrc, n_RegSrc, n_FlagW;
  logic [5:0] n_ALUControl;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  multicycle_control u_dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd), .IsMul(IsMul),
    .IRWrite(IRWrite), .NextPC(NextPC), .RegW(RegW), .MemW(MemW), .PCS(PCS),
    .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
    .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl), .FlagW(FlagW),
    .Illegal(Illegal)
  );

  multicycle_control #(.ALUCTL_W(6), .MUL_EN(0), .MUL_LAT(4)) u_nomul (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd), .IsMul(IsMul),
    .IRWrite(n_IRWrite), .NextPC(n_NextPC), .RegW(n_RegW), .MemW(n_MemW), .PCS(n_PCS),
    .AdrSrc(n_AdrSrc), .ALUSrcA(n_ALUSrcA), .ALUSrcB(n_ALUSrcB), .ResultSrc(n_ResultSrc),
    .ImmSrc(n_ImmSrc), .RegSrc(n_RegSrc), .ALUControl(n_ALUControl), .FlagW(n_FlagW),
    .Illegal(n_Illegal)
  );

  // {IRWrite,NextPC,RegW,MemW,PCS,AdrSrc,ALUSrcA,ALUSrcB,ResultSrc}
  localparam logic [10:0] C_ZERO   = 11'b00000_0_0_00_00;
  localparam logic [10:0] C_FETCH  = 11'b11000_0_1_10_10;
  localparam logic [10:0] C_DECODE = 11'b00000_0_1_10_10;
  localparam logic [10:0] C_MEMADR = 11'b00000_0_0_01_00;
  localparam logic [10:0] C_MEMRD  = 11'b00000_1_0_00_00;
  localparam logic [10:0] C_MEMWB  = 11'b00100_0_0_00_01;
  localparam logic [10:0] C_MEMWR  = 11'b00010_1_0_00_00;
  localparam logic [10:0] C_EXECR  = 11'b00000_0_0_00_00;
  localparam logic [10:0] C_EXECI  = 11'b00000_0_0_01_00;
  localparam logic [10:0] C_ALUWB  = 11'b00100_0_0_00_00;
  localparam logic [10:0] C_ALUWBP = 11'b00101_0_0_00_00;
  localparam logic [10:0] C_BRANCH = 11'b00001_0_0_01_10;

  logic [21:0] obs_v;
  assign obs_v = {IRWrite, NextPC, RegW, MemW, PCS, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
                  ImmSrc, RegSrc, ALUControl, FlagW, Illegal};

  task automatic chk(input string tag, input logic [21:0] obs, input logic [21:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic ex(input string tag, input logic [10:0] ctl, input logic [1:0] imm,
                    input logic [1:0] rsrc, input logic [3:0] aluc,
                    input logic [1:0] fw, input logic ill);
    chk(tag, obs_v, {ctl, imm, rsrc, aluc, fw, ill});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [1:0] op, input logic [5:0] fn,
                           input logic [3:0] rd, input logic mul);
    Op = op; Funct = fn; Rd = rd; IsMul = mul;
    #1;
  endtask

  initial begin
    reset = 1'b1;
    Op = 2'b00; Funct = 6'b000000; Rd = 4'b0000; IsMul = 1'b0;
    step();
    ex("rst_a", C_ZERO, 2'b00, 2'b00, 4'b0000, 2'b00, 1'b0);
    step();
    ex("rst_b", C_ZERO, 2'b00, 2'b00, 4'b0000, 2'b00, 1'b0);

    // MUL R2: 4 MULWAIT cycles; MUL_EN=0 instance flags it illegal
    set_instr(2'b00, 6'b000000, 4'b0010, 1'b1);
    reset = 1'b0;
    #1;
    ex("mul_fetch", C_FETCH, 2'b00, 2'b00, 4'b0000, 2'b00, 1'b0);
    chk("nomul_fetch", 22'(n_IRWrite), 22'd1);
    step();
    ex("mul_dec", C_DECODE, 2'b00, 2'b00, 4'b0000, 2'b00, 1'b0);
    chk("nomul_ill", 22'(n_Illegal), 22'd1);
    for (int i = 0; i < 4; i++) begin
      step();
      ex("mul_wait", C_ZERO, 2'b00, 2'b00, 4'b0101, 2'b00, 1'b0);
      if (i == 0) begin
        chk("nomul_refetch", 22'({n_IRWrite, n_Illegal}), 22'b10);
      end
    end
    step();
    ex("mul_wb", C_ALUWB, 2'b00, 2'b00, 4'b0101, 2'b00, 1'b0);
    step();
    ex("mul_end", C_FETCH, 2'b00, 2'b00, 4'b0000, 2'b00, 1'b0);

    // Reset in the 2nd MULWAIT cycle aborts the multiply
    step();
    ex("mulr_dec", C_DECODE, 2'b00, 2'b00, 4'b0000, 2'b00, 1'b0);
    step();
    ex("mulr_w1", C_ZERO, 2'b00, 2'b00, 4'b0101, 2'b00, 1'b0);
    step();
    ex("mulr_w2", C_ZERO, 2'b00, 2'b00, 4'b0101, 2'b00, 1'b0);
    reset = 1'b1;
    #1;
    ex("mulr_rst_a", C_ZERO, 2'b00, 2'b00, 4'b0000, 2'b00, 1'b0);
    step();
    ex("mulr_rst_b", C_ZERO, 2'b00, 2'b00, 4'b0000, 2'b00, 1'b0);
    reset = 1'b0;
    #1;
    ex("mulr_fetch", C_FETCH, 2'b00, 2'b00, 4'b0000, 2'b00, 1'b0);
    chk("mulr_nomul_fetch", 22'(n_IRWrite), 22'd1);

    // ADD R1,R2,R3
    set_instr(2'b00, 6'b001000, 4'b0001, 1'b0);
    ex("add_fetch", C_FETCH, 2'b00, 2'b00, 4'b0000, 2'b00, 1'b0);
    step(); ex("add_dec", C_DECODE, 2'b00, 2'b00, 4'b0000, 2'b00, 1'b0);
    step(); ex("add_exec", C_EXECR, 2'b00, 2'b00, 4'b0000, 2'b00, 1'b0);
    step(); ex("add_wb", C_ALUWB, 2'b00, 2'b00, 4'b0000, 2'b00, 1'b0);
    step(); ex("add_end", C_FETCH, 2'b00, 2'b00, 4'b0000, 2'b00, 1'b0);

    // LDR
    set_instr(2'b01, 6'b011001, 4'b0011, 1'b0);
    ex("ldr_fetch", C_FETCH, 2'b01, 2'b00, 4'b0000, 2'b00, 1'b0);
    step(); ex("ldr_dec", C_DECODE, 2'b01, 2'b00, 4'b0000, 2'b00, 1'b0);
    step(); ex("ldr_adr", C_MEMADR, 2'b01, 2'b00, 4'b0000, 2'b00, 1'b0);
    step(); ex("ldr_rd", C_MEMRD, 2'b01, 2'b00, 4'b0000, 2'b00, 1'b0);
    step(); ex("ldr_wb", C_MEMWB, 2'b01, 2'b00, 4'b0000, 2'b00, 1'b0);
    step(); ex("ldr_end", C_FETCH, 2'b01, 2'b00, 4'b0000, 2'b00, 1'b0);

    // STR
    set_instr(2'b01, 6'b011000, 4'b0011, 1'b0);
    ex("str_fetch", C_FETCH, 2'b01, 2'b10, 4'b0000, 2'b00, 1'b0);
    step(); ex("str_dec", C_DECODE, 2'b01, 2'b10, 4'b0000, 2'b00, 1'b0);
    step(); ex("str_adr", C_MEMADR, 2'b01, 2'b10, 4'b0000, 2'b00, 1'b0);
    step(); ex("str_wr", C_MEMWR, 2'b01, 2'b10, 4'b0000, 2'b00, 1'b0);
    step(); ex("str_end", C_FETCH, 2'b01, 2'b10, 4'b0000, 2'b00, 1'b0);

    // CMP: flags only, no writeback
    set_instr(2'b00, 6'b010101, 4'b0000, 1'b0);
    step(); ex("cmp_dec", C_DECODE, 2'b00, 2'b00, 4'b0000, 2'b00, 1'b0);
    step(); ex("cmp_exec", C_EXECR, 2'b00, 2'b00, 4'b0001, 2'b11, 1'b0);
    step(); ex("cmp_end", C_FETCH, 2'b00, 2'b00, 4'b0000, 2'b00, 1'b0);

    // EORS: FlagW[0] stays 0 for a logic op
    set_instr(2'b00, 6'b000011, 4'b0100, 1'b0);
    step(); ex("eors_dec", C_DECODE, 2'b00, 2'b00, 4'b0000, 2'b00, 1'b0);
    step(); ex("eors_exec", C_EXECR, 2'b00, 2'b00, 4'b0100, 2'b10, 1'b0);
    step(); ex("eors_wb", C_ALUWB, 2'b00, 2'b00, 4'b0100, 2'b00, 1'b0);
    step(); ex("eors_end", C_FETCH, 2'b00, 2'b00, 4'b0000, 2'b00, 1'b0);

    // ADDS R15, immediate: PCS in ALUWB
    set_instr(2'b00, 6'b101001, 4'b1111, 1'b0);
    step(); ex("addi_dec", C_DECODE, 2'b00, 2'b00, 4'b0000, 2'b00, 1'b0);
    step(); ex("addi_exec", C_EXECI, 2'b00, 2'b00, 4'b0000, 2'b11, 1'b0);
    step(); ex("addi_wb", C_ALUWBP, 2'b00, 2'b00, 4'b0000, 2'b00, 1'b0);
    step(); ex("addi_end", C_FETCH, 2'b00, 2'b00, 4'b0000, 2'b00, 1'b0);

    // B
    set_instr(2'b10, 6'b000000, 4'b0000, 1'b0);
    ex("b_fetch", C_FETCH, 2'b10, 2'b01, 4'b0000, 2'b00, 1'b0);
    step(); ex("b_dec", C_DECODE, 2'b10, 2'b01, 4'b0000, 2'b00, 1'b0);
    step(); ex("b_br", C_BRANCH, 2'b10, 2'b01, 4'b0000, 2'b00, 1'b0);
    step(); ex("b_end", C_FETCH, 2'b10, 2'b01, 4'b0000, 2'b00, 1'b0);

    // Op=11: one-cycle Illegal, then fetch
    set_instr(2'b11, 6'b000000, 4'b0000, 1'b0);
    step(); ex("op11_dec", C_DECODE, 2'b00, 2'b00, 4'b0000, 2'b00, 1'b1);
    step(); ex("op11_end", C_FETCH, 2'b00, 2'b00, 4'b0000, 2'b00, 1'b0);

    // CMP without S is unsupported
    set_instr(2'b00, 6'b010100, 4'b0000, 1'b0);
    step(); ex("cmp0_dec", C_DECODE, 2'b00, 2'b00, 4'b0000, 2'b00, 1'b1);
    step(); ex("cmp0_end", C_FETCH, 2'b00, 2'b00, 4'b0000, 2'b00, 1'b0);

    // Unlisted cmd 0011 is unsupported
    set_instr(2'b00, 6'b000110, 4'b0001, 1'b0);
    step(); ex("rsb_dec", C_DECODE, 2'b00, 2'b00, 4'b0000, 2'b00, 1'b1);
    step(); ex("rsb_end", C_FETCH, 2'b00, 2'b00, 4'b0000, 2'b00, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
